// File: rtl/ram_s1p_rr_arb.sv
// Round-robin arbiter that serialises NUM_REQ requesters onto one single-port RAM.
// Read data returns one cycle after the grant and is routed back by a one-hot valid pulse.

module ram_s1p_rr_arb_chk #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int PTR_W      = 1
) (
  input logic                                clk_i,
  input logic                                rstn_i,
  input logic [NUM_REQ-1:0]                  req_valid_i,
  input logic [NUM_REQ-1:0]                  req_we_i,
  input logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr_i,
  input logic                                gnt,
  input logic [PTR_W-1:0]                    gnt_idx,
  input logic [NUM_REQ-1:0]                  req_ready_o,
  input logic [NUM_REQ-1:0]                  rsp_valid_o
);

  a_valid_known: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !$isunknown(req_valid_i));

  a_gnt_known: assert property (@(posedge clk_i) disable iff (!rstn_i)
    gnt |-> !$isunknown({req_we_i[gnt_idx], req_addr_i[gnt_idx]}));

  a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rstn_i)
    $onehot0(req_ready_o) && ((req_ready_o & ~req_valid_i) == '0));

  a_rsp_onehot: assert property (@(posedge clk_i) disable iff (!rstn_i)
    $onehot0(rsp_valid_o));

endmodule

module ram_s1p_rr_arb #(
  parameter int  WORD_WIDTH = 8,
  parameter int  WORD_COUNT = 256,
  parameter int  NUM_REQ    = 2,
  localparam int ADDR_WIDTH = $clog2(WORD_COUNT)
) (
  input  logic                                clk_i,
  input  logic                                rstn_i,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  input  logic [NUM_REQ-1:0]                  req_we_i,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [NUM_REQ-1:0][WORD_WIDTH-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]                  rsp_valid_o,
  output logic [WORD_WIDTH-1:0]               rsp_data_o,
  output logic                                ram_we_o,
  output logic [ADDR_WIDTH-1:0]               ram_addr_o,
  output logic [WORD_WIDTH-1:0]               ram_data_o,
  input  logic [WORD_WIDTH-1:0]               ram_data_i
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]      ptr_r;
  logic [PTR_W-1:0]      ptr_nxt_s;
  logic [PTR_W-1:0]      scan_s;
  logic [PTR_W-1:0]      gnt_idx_s;
  logic                  gnt_found_s;
  logic                  gnt_s;
  logic [NUM_REQ-1:0]    ready_s;
  logic [NUM_REQ-1:0]    rsp_valid_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [WORD_WIDTH-1:0] data_r;

  // Round-robin scan: first valid requester at or after ptr_r, wrapping at NUM_REQ.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = ptr_r;
    scan_s      = ptr_r;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found_s && req_valid_i[scan_s]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = scan_s;
      end else begin
        gnt_found_s = gnt_found_s;
      end
      if (scan_s == PTR_W'(NUM_REQ - 1)) begin
        scan_s = '0;
      end else begin
        scan_s = scan_s + PTR_W'(1);
      end
    end
  end

  // Reset masks the grant so nothing is accepted while rstn_i is low.
  assign gnt_s = gnt_found_s & rstn_i;

  // Grant decode, RAM port mux (live on grant, held value otherwise) and pointer advance.
  always_comb begin
    ready_s    = '0;
    ram_we_o   = 1'b0;
    ram_addr_o = addr_r;
    ram_data_o = data_r;
    ptr_nxt_s  = ptr_r;
    if (gnt_s) begin
      ready_s[gnt_idx_s] = 1'b1;
      ram_we_o           = req_we_i[gnt_idx_s];
      ram_addr_o         = req_addr_i[gnt_idx_s];
      ram_data_o         = req_data_i[gnt_idx_s];
      if (gnt_idx_s == PTR_W'(NUM_REQ - 1)) begin
        ptr_nxt_s = '0;
      end else begin
        ptr_nxt_s = gnt_idx_s + PTR_W'(1);
      end
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // Pointer, held RAM port values and the one-cycle read response pulse.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ptr_r       <= '0;
      addr_r      <= '0;
      data_r      <= '0;
      rsp_valid_r <= '0;
    end else begin
      ptr_r <= ptr_nxt_s;
      if (gnt_s) begin
        addr_r <= ram_addr_o;
        data_r <= ram_data_o;
      end
      rsp_valid_r <= (gnt_s && !ram_we_o) ? ready_s : '0;
    end
  end

  assign req_ready_o = ready_s;
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_data_o  = ram_data_i;

  ram_s1p_rr_arb_chk #(
    .NUM_REQ    (NUM_REQ),
    .ADDR_WIDTH (ADDR_WIDTH),
    .PTR_W      (PTR_W)
  ) u_chk (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .req_valid_i (req_valid_i),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .gnt         (gnt_s),
    .gnt_idx     (gnt_idx_s),
    .req_ready_o (req_ready_o),
    .rsp_valid_o (rsp_valid_o)
  );

endmodule

// File: tb/tb_ram_s1p_rr_arb.sv
// Directed bench: a 4-requester instance driven from a vector table, and a
// 2-requester instance for contention and reset-during-read sequences.

module tb_ram_s1p_rr_arb;

  logic clk;
  logic rst4;
  logic rst2;
  int   checks;
  int   errors;

  // 4-requester instance
  logic [3:0]      v4, we4, rdy4, rv4;
  logic [3:0][7:0] a4, d4;
  logic [7:0]      rd4, raddr4, rdo4, ramq4;
  logic            rwe4;
  logic [7:0]      mem4 [256];

  // 2-requester instance
  logic [1:0]      v2, we2, rdy2, rv2;
  logic [1:0][7:0] a2, d2;
  logic [7:0]      rd2, raddr2, rdo2, ramq2;
  logic            rwe2;
  logic [7:0]      mem2 [256];

  ram_s1p_rr_arb #(.WORD_WIDTH(8), .WORD_COUNT(256), .NUM_REQ(4)) dut4 (
    .clk_i(clk), .rstn_i(rst4), .req_valid_i(v4), .req_ready_o(rdy4),
    .req_we_i(we4), .req_addr_i(a4), .req_data_i(d4), .rsp_valid_o(rv4),
    .rsp_data_o(rd4), .ram_we_o(rwe4), .ram_addr_o(raddr4), .ram_data_o(rdo4),
    .ram_data_i(ramq4));

  ram_s1p_rr_arb #(.WORD_WIDTH(8), .WORD_COUNT(256), .NUM_REQ(2)) dut2 (
    .clk_i(clk), .rstn_i(rst2), .req_valid_i(v2), .req_ready_o(rdy2),
    .req_we_i(we2), .req_addr_i(a2), .req_data_i(d2), .rsp_valid_o(rv2),
    .rsp_data_o(rd2), .ram_we_o(rwe2), .ram_addr_o(raddr2), .ram_data_o(rdo2),
    .ram_data_i(ramq2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first single-port RAM models with one-cycle read latency.
  always @(posedge clk) begin
    if (rwe4) mem4[raddr4] <= rdo4;
    ramq4 <= mem4[raddr4];
    if (rwe2) mem2[raddr2] <= rdo2;
    ramq2 <= mem2[raddr2];
  end

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  we;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  e_rdy;
    logic        e_we;
    logic [7:0]  e_addr;
    logic [7:0]  e_data;
    logic [3:0]  e_rv;
    logic [7:0]  e_rd;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] we,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] e_rdy, input logic e_we,
                              input logic [7:0] e_addr, input logic [7:0] e_data,
                              input logic [3:0] e_rv, input logic [7:0] e_rd);
    vec_t r;
    r.v = v; r.we = we; r.a = a; r.d = d; r.e_rdy = e_rdy; r.e_we = e_we;
    r.e_addr = e_addr; r.e_data = e_data; r.e_rv = e_rv; r.e_rd = e_rd;
    return r;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    // Address fields are {req3,req2,req1,req0}; non-valid lanes carry junk.
    tbl[0]  = mk(4'b0001, 4'b0001, 32'h00000010, 32'h000000A5, 4'b0001, 1'b1, 8'h10, 8'hA5, 4'b0000, 8'h00);
    tbl[1]  = mk(4'b0001, 4'b0000, 32'h00000010, 32'h00000000, 4'b0001, 1'b0, 8'h10, 8'h00, 4'b0000, 8'h00);
    tbl[2]  = mk(4'b0000, 4'b1110, 32'hEEDDCC00, 32'h99887766, 4'b0000, 1'b0, 8'h10, 8'h00, 4'b0001, 8'hA5);
    tbl[3]  = mk(4'b1000, 4'b0110, 32'h10333300, 32'h00000000, 4'b1000, 1'b0, 8'h10, 8'h00, 4'b0000, 8'h00);
    tbl[4]  = mk(4'b0101, 4'b0001, 32'h00200020, 32'h0000005A, 4'b0001, 1'b1, 8'h20, 8'h5A, 4'b1000, 8'hA5);
    tbl[5]  = mk(4'b0100, 4'b0000, 32'h00200000, 32'h00000000, 4'b0100, 1'b0, 8'h20, 8'h00, 4'b0000, 8'h00);
    tbl[6]  = mk(4'b0010, 4'b0010, 32'h00000500, 32'h00003C00, 4'b0010, 1'b1, 8'h05, 8'h3C, 4'b0100, 8'h5A);
    tbl[7]  = mk(4'b0001, 4'b0000, 32'h00000005, 32'h00000000, 4'b0001, 1'b0, 8'h05, 8'h00, 4'b0000, 8'h00);
    tbl[8]  = mk(4'b0010, 4'b0010, 32'h00007F00, 32'h00007700, 4'b0010, 1'b1, 8'h7F, 8'h77, 4'b0001, 8'h3C);
    tbl[9]  = mk(4'b0000, 4'b1111, 32'h01020304, 32'hFFFFFFFF, 4'b0000, 1'b0, 8'h7F, 8'h77, 4'b0000, 8'h00);
    tbl[10] = tbl[9];
    tbl[11] = tbl[9];

    // Reset state, with requests asserted to show nothing is granted.
    rst4 = 1'b0; rst2 = 1'b0;
    v4 = 4'b1111; we4 = 4'b1111; a4 = 32'h11223344; d4 = 32'h55667788;
    v2 = 2'b11;   we2 = 2'b11;   a2 = 16'h1122;     d2 = 16'h3344;
    @(negedge clk);
    chk("rst rdy4", 32'(rdy4), 32'h0);
    chk("rst rv4", 32'(rv4), 32'h0);
    chk("rst we4", 32'(rwe4), 32'h0);
    chk("rst addr4", 32'(raddr4), 32'h0);
    chk("rst data4", 32'(rdo4), 32'h0);
    chk("rst rdy2", 32'(rdy2), 32'h0);
    v4 = '0; we4 = '0; v2 = '0; we2 = '0;
    #2 rst4 = 1'b1;
    @(posedge clk); #1;

    // Table: one row per cycle, compared mid-cycle.
    for (int i = 0; i < 12; i++) begin
      v4 = tbl[i].v; we4 = tbl[i].we; a4 = tbl[i].a; d4 = tbl[i].d;
      @(negedge clk);
      chk($sformatf("row%0d rdy", i), 32'(rdy4), 32'(tbl[i].e_rdy));
      chk($sformatf("row%0d ram_we", i), 32'(rwe4), 32'(tbl[i].e_we));
      chk($sformatf("row%0d ram_addr", i), 32'(raddr4), 32'(tbl[i].e_addr));
      chk($sformatf("row%0d ram_data", i), 32'(rdo4), 32'(tbl[i].e_data));
      chk($sformatf("row%0d rsp_valid", i), 32'(rv4), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv != 4'b0000) begin
        chk($sformatf("row%0d rsp_data", i), 32'(rd4), 32'(tbl[i].e_rd));
      end
      @(posedge clk); #1;
    end
    v4 = '0;

    // Contention on the 2-requester instance: grants alternate 0,1,0,1.
    @(negedge clk);
    rst2 = 1'b1;
    @(posedge clk); #1;
    v2 = 2'b11; we2 = 2'b01; a2 = {8'h02, 8'h01}; d2 = {8'h00, 8'h11};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("cont%0d rdy", c), 32'(rdy2), (c % 2 == 0) ? 32'h1 : 32'h2);
      chk($sformatf("cont%0d ram_we", c), 32'(rwe2), (c % 2 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("cont%0d ram_addr", c), 32'(raddr2), (c % 2 == 0) ? 32'h01 : 32'h02);
      chk($sformatf("cont%0d rsp_valid", c), 32'(rv2), (c == 2) ? 32'h2 : 32'h0);
      @(posedge clk); #1;
    end

    // Read by req1 granted, then reset asserted before the edge that would launch its response.
    v2 = 2'b10;
    @(negedge clk);
    chk("mid rdy", 32'(rdy2), 32'h2);
    #2 rst2 = 1'b0;
    #1;
    chk("mid rst rdy", 32'(rdy2), 32'h0);
    chk("mid rst ram_we", 32'(rwe2), 32'h0);
    chk("mid rst ram_addr", 32'(raddr2), 32'h0);
    chk("mid rst ram_data", 32'(rdo2), 32'h0);
    @(posedge clk); #1;
    chk("mid rst rsp_valid", 32'(rv2), 32'h0);

    // First grant after release follows ptr = 0.
    v2 = 2'b11;
    @(negedge clk);
    rst2 = 1'b1;
    #1;
    chk("post rst rdy", 32'(rdy2), 32'h1);
    chk("post rst rsp_valid", 32'(rv2), 32'h0);
    @(posedge clk); #1;
    v2 = 2'b00;
    @(negedge clk);
    chk("post write no rsp", 32'(rv2), 32'h0);
    chk("post idle ram_we", 32'(rwe2), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
